// File: rtl/frame_loader.sv
// frame_loader: assembles SPI bytes into pixels, writes them to the back buffer,
// and flips the front buffer once a complete, error-free frame has been loaded.
module frame_loader #(
    parameter int rows    = 8,
    parameter int columns = 32,
    parameter int width   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data,
    input  logic                       valid,
    input  logic                       sot,
    input  logic                       eot,
    input  logic                       flip_safe,
    output logic                       wen,
    output logic [$clog2(rows)-1:0]    wrow,
    output logic [$clog2(columns)-1:0] wcol,
    output logic [width-1:0]           wdata,
    output logic                       flip,
    output logic                       busy,
    output logic                       frame_err
);
    localparam int RW = $clog2(rows);
    localparam int CW = $clog2(columns);
    localparam logic [RW-1:0] LAST_ROW = RW'(rows - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(columns - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        FLIP_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              flip_q, flip_d;
    logic              wen_q, wen_d;
    logic [width-1:0]  wdata_q, wdata_d;
    logic [width-1:0]  asm_q, asm_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [width-1:0]  shifted;
    logic              at_last;

    assign shifted = {asm_q[width-9:0], data};
    assign at_last = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        full_d  = full_q;
        err_d   = err_q;
        flip_d  = flip_q;
        wen_d   = 1'b0;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        row_d   = row_q;
        col_d   = col_q;
        // Address moves on the cycle after each write and sticks at the last pixel.
        if (wen_q && !at_last) begin
            col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
            row_d = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
        end
        case (state_q)
            IDLE: begin
                if (valid && sot) begin
                    state_d = LOAD;
                    bcnt_d  = 2'd1;
                    asm_d   = shifted;
                    row_d   = '0;
                    col_d   = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (valid && sot) begin
                    err_d  = 1'b1;
                    bcnt_d = 2'd1;
                    asm_d  = shifted;
                    row_d  = '0;
                    col_d  = '0;
                    full_d = 1'b0;
                end else if (valid && full_q) begin
                    err_d = 1'b1;
                end else if (valid) begin
                    asm_d  = shifted;
                    bcnt_d = (bcnt_q == 2'd2) ? 2'd0 : bcnt_q + 2'd1;
                    if (bcnt_q == 2'd2) begin
                        wen_d   = 1'b1;
                        wdata_d = shifted;
                        full_d  = at_last;
                    end
                end
                // A byte arriving with eot is already folded into full_d/bcnt_d.
                if (eot) begin
                    if (full_d && bcnt_d == 2'd0 && !err_d) begin
                        state_d = FLIP_WAIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            FLIP_WAIT: begin
                if (valid && sot) err_d = 1'b1;
                if (flip_safe) begin
                    flip_d  = ~flip_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            flip_q  <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            asm_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            full_q  <= full_d;
            err_q   <= err_d;
            flip_q  <= flip_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign wen       = wen_q;
    assign wrow      = row_q;
    assign wcol      = col_q;
    assign wdata     = wdata_q;
    assign flip      = flip_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = err_q;
endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed scenario tasks for frame_loader with a write recorder.
module tb_frame_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data = '0;
    logic        valid = 1'b0, sot = 1'b0, eot = 1'b0, flip_safe = 1'b1;
    logic        wen, flip, busy, frame_err;
    logic [2:0]  wrow;
    logic [4:0]  wcol;
    logic [23:0] wdata;

    int checks = 0;
    int errors = 0;
    int total_wen = 0;
    logic [23:0] rec_data [4096];
    logic [2:0]  rec_row  [4096];
    logic [4:0]  rec_col  [4096];
    logic        exp_flip = 1'b0;

    frame_loader dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid), .sot(sot), .eot(eot),
        .flip_safe(flip_safe), .wen(wen), .wrow(wrow), .wcol(wcol), .wdata(wdata),
        .flip(flip), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen) begin
            if (total_wen < 4096) begin
                rec_data[total_wen] = wdata;
                rec_row[total_wen]  = wrow;
                rec_col[total_wen]  = wcol;
            end
            total_wen = total_wen + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int b, input logic s, input logic e);
        cyc();
        data = b[7:0]; valid = 1'b1; sot = s; eot = e;
        cyc();
        valid = 1'b0; sot = 1'b0; eot = 1'b0;
    endtask

    task automatic send_eot();
        cyc();
        eot = 1'b1;
        cyc();
        eot = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic eot_last);
        for (int i = 0; i < n; i++) send_byte(i, i == 0, eot_last && i == n - 1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if ({wen, wrow, wcol, wdata, flip, busy, frame_err} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got wen=%b row=%0d col=%0d data=%h flip=%b busy=%b err=%b, want all 0",
                     wen, wrow, wcol, wdata, flip, busy, frame_err);
        end
        cyc();
        rst = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_full_frame();
        int base, bad;
        base = total_wen;
        send_frame(768, 1'b0);
        send_eot();
        repeat (4) cyc();
        exp_flip = ~exp_flip;
        checks++;
        if (total_wen - base !== 256) begin
            errors++;
            $display("FAIL full_wen_count: got %0d want 256", total_wen - base);
        end
        checks++;
        if ({rec_row[base], rec_col[base], rec_data[base]} !== {3'd0, 5'd0, 24'h000102}) begin
            errors++;
            $display("FAIL full_first_pixel: got (%0d,%0d) %h want (0,0) 000102", rec_row[base], rec_col[base], rec_data[base]);
        end
        checks++;
        if ({rec_row[base+32], rec_col[base+32], rec_data[base+32]} !== {3'd1, 5'd0, 24'h606162}) begin
            errors++;
            $display("FAIL full_pixel32: got (%0d,%0d) %h want (1,0) 606162", rec_row[base+32], rec_col[base+32], rec_data[base+32]);
        end
        checks++;
        if ({rec_row[base+255], rec_col[base+255], rec_data[base+255]} !== {3'd7, 5'd31, 24'hFDFEFF}) begin
            errors++;
            $display("FAIL full_last_pixel: got (%0d,%0d) %h want (7,31) fdfeff", rec_row[base+255], rec_col[base+255], rec_data[base+255]);
        end
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            logic [7:0] b0, b1, b2;
            b0 = 8'((3 * k) % 256); b1 = 8'((3 * k + 1) % 256); b2 = 8'((3 * k + 2) % 256);
            if ({rec_row[base+k], rec_col[base+k], rec_data[base+k]} !== {3'(k / 32), 5'(k % 32), b0, b1, b2}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_pixel_stream: got %0d wrong pixels want 0", bad);
        end
        checks++;
        if ({flip, frame_err, busy} !== {exp_flip, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_end_state: got flip=%b err=%b busy=%b want flip=%b err=0 busy=0", flip, frame_err, busy, exp_flip);
        end
    endtask

    task automatic test_flip_wait();
        int base, bad;
        flip_safe = 1'b0;
        base = total_wen;
        send_frame(768, 1'b0);
        send_eot();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            valid = (i % 4 == 0);
            data  = 8'(i);
            @(negedge clk);
            if (busy !== 1'b1 || flip !== exp_flip) bad++;
        end
        cyc();
        valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wait_hold: got %0d cycles with busy!=1 or flip!=%b want 0", bad, exp_flip);
        end
        checks++;
        if (total_wen - base !== 256) begin
            errors++;
            $display("FAIL wait_no_wen: got %0d writes want 256", total_wen - base);
        end
        flip_safe = 1'b1;
        @(negedge clk);
        checks++;
        if (flip !== exp_flip) begin
            errors++;
            $display("FAIL wait_flip_same_cycle: got %b want %b", flip, exp_flip);
        end
        exp_flip = ~exp_flip;
        @(negedge clk);
        checks++;
        if ({flip, busy, frame_err} !== {exp_flip, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wait_flip_next: got flip=%b busy=%b err=%b want flip=%b busy=0 err=0", flip, busy, frame_err, exp_flip);
        end
    endtask

    task automatic test_short_frame();
        int base, bad;
        base = total_wen;
        send_frame(300, 1'b0);
        send_eot();
        repeat (4) cyc();
        checks++;
        if (total_wen - base !== 100) begin
            errors++;
            $display("FAIL short_wen_count: got %0d want 100", total_wen - base);
        end
        bad = 0;
        for (int k = 0; k < 100; k++)
            if ({rec_row[base+k], rec_col[base+k]} !== {3'(k / 32), 5'(k % 32)}) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL short_addresses: got %0d wrong addresses want 0", bad);
        end
        checks++;
        if ({frame_err, flip, busy} !== {1'b1, exp_flip, 1'b0}) begin
            errors++;
            $display("FAIL short_end_state: got err=%b flip=%b busy=%b want err=1 flip=%b busy=0", frame_err, flip, busy, exp_flip);
        end
    endtask

    task automatic test_overlong();
        int base;
        base = total_wen;
        send_frame(770, 1'b0);
        send_eot();
        repeat (4) cyc();
        checks++;
        if (total_wen - base !== 256) begin
            errors++;
            $display("FAIL long_wen_count: got %0d want 256", total_wen - base);
        end
        checks++;
        if ({rec_row[total_wen-1], rec_col[total_wen-1]} !== {3'd7, 5'd31}) begin
            errors++;
            $display("FAIL long_saturate: got (%0d,%0d) want (7,31)", rec_row[total_wen-1], rec_col[total_wen-1]);
        end
        checks++;
        if ({frame_err, flip, busy} !== {1'b1, exp_flip, 1'b0}) begin
            errors++;
            $display("FAIL long_end_state: got err=%b flip=%b busy=%b want err=1 flip=%b busy=0", frame_err, flip, busy, exp_flip);
        end
        send_byte(0, 1'b1, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL long_err_clear_on_sot: got %b want 0", frame_err);
        end
        for (int i = 1; i < 768; i++) send_byte(i, 1'b0, 1'b0);
        send_eot();
        repeat (4) cyc();
        exp_flip = ~exp_flip;
        checks++;
        if ({frame_err, flip} !== {1'b0, exp_flip}) begin
            errors++;
            $display("FAIL long_recovery: got err=%b flip=%b want err=0 flip=%b", frame_err, flip, exp_flip);
        end
    endtask

    task automatic test_restart();
        int base;
        for (int i = 0; i < 10; i++) send_byte(i, i == 0, 1'b0);
        base = total_wen;
        send_frame(768, 1'b0);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL restart_err: got %b want 1", frame_err);
        end
        checks++;
        if ({rec_row[base], rec_col[base], rec_data[base]} !== {3'd0, 5'd0, 24'h000102}) begin
            errors++;
            $display("FAIL restart_first_wen: got (%0d,%0d) %h want (0,0) 000102", rec_row[base], rec_col[base], rec_data[base]);
        end
        send_eot();
        repeat (4) cyc();
        checks++;
        if ({frame_err, flip, busy} !== {1'b1, exp_flip, 1'b0}) begin
            errors++;
            $display("FAIL restart_no_flip: got err=%b flip=%b busy=%b want err=1 flip=%b busy=0", frame_err, flip, busy, exp_flip);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(400, 1'b0);
        rst = 1'b0;
        #1;
        exp_flip = 1'b0;
        checks++;
        if ({wen, wrow, wcol, wdata, flip, busy, frame_err} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got wen=%b row=%0d col=%0d data=%h flip=%b busy=%b err=%b, want all 0",
                     wen, wrow, wcol, wdata, flip, busy, frame_err);
        end
        repeat (2) cyc();
        rst = 1'b1;
        send_eot();
        repeat (4) cyc();
        checks++;
        if ({flip, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_no_flip: got flip=%b busy=%b want 0 0", flip, busy);
        end
    endtask

    task automatic test_eot_with_last();
        int base;
        base = total_wen;
        send_frame(768, 1'b1);
        repeat (4) cyc();
        exp_flip = ~exp_flip;
        checks++;
        if (total_wen - base !== 256) begin
            errors++;
            $display("FAIL eot_last_wen_count: got %0d want 256", total_wen - base);
        end
        checks++;
        if ({flip, frame_err, busy} !== {exp_flip, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL eot_last_flip: got flip=%b err=%b busy=%b want flip=%b err=0 busy=0", flip, frame_err, busy, exp_flip);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flip_wait();
        test_short_frame();
        test_overlong();
        test_restart();
        test_reset_mid();
        test_eot_with_last();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
